// File: rtl/v850_seq_pkg.sv
// ---------------------------------------------------------------------------
// v850_seq_pkg
// Shared types and constants for the V850 multi-cycle instruction sequencer:
// the sequencer state encoding, the exception codes the sequencer itself
// generates, and the PC step sizes for 16- and 32-bit instructions.
// ---------------------------------------------------------------------------
package v850_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_EXC    = 3'd6,
    ST_HALT   = 3'd7
  } seq_state_t;

  localparam logic [15:0] ECODE_NMI     = 16'h0010;
  localparam logic [15:0] ECODE_TIMEOUT = 16'h0060;

  localparam logic [2:0]  PC_INC16      = 3'd2;
  localparam logic [2:0]  PC_INC32      = 3'd4;

  // PC step for a sequentially retiring instruction of the given length.
  function automatic logic [2:0] pc_step(input logic is32);
    return is32 ? PC_INC32 : PC_INC16;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// ---------------------------------------------------------------------------
// seq_watchdog
// Counts cycles the sequencer spends waiting in EXEC or MEM and flags the
// cycle in which the WDT_CYCLES-th consecutive wait cycle occurs.
//   clk, rst   : core clock, synchronous active-high reset
//   clear_i    : restart the count (asserted on every sequencer state change)
//   en_i       : this cycle is a wait cycle (no done/ack arrived)
//   expired_o  : this wait cycle is the WDT_CYCLES-th one
// ---------------------------------------------------------------------------
module seq_watchdog #(
  parameter int unsigned WDT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned    CW   = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES + 1) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WDT_CYCLES - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // cnt_q holds the number of wait cycles already seen, so the current wait
  // cycle is the last allowed one when cnt_q == WDT_CYCLES-1.
  assign expired_o = en_i && (cnt_q == LAST);

  // Next-count logic: clear wins, saturate at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/v850_sequencer.sv
// ---------------------------------------------------------------------------
// v850_sequencer
// Multi-cycle instruction sequencer: IDLE -> FETCH -> DECODE -> EXEC ->
// [MEM] -> WB, with HALT, interrupt/NMI entry at instruction boundaries and
// an EXEC/MEM watchdog raising an FE-level timeout exception.
//   fetch_ack_i, mem_ack_i, ex_done_i : handshakes from fetch/memory/executer
//   dec_*_i                           : decoded attributes of the instruction
//   irq_i/irq_code_i, nmi_i, psw_*_i  : interrupt sources and their masks
//   fetch_req_o, dec_en_o, ex_en_o, mem_req_o, wb_en_o : stage strobes
//   pc_inc_o, pc_load_o               : PC update in WB
//   exc_take_o, exc_fe_o, exc_code_o  : exception entry
//   state_o, instret_o                : current state, retired count
// Every output is a decode of, or a copy of, a register.
// ---------------------------------------------------------------------------
module v850_sequencer
  import v850_seq_pkg::*;
#(
  parameter int unsigned WDT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_ack_i,
  input  logic        dec_is32_i,
  input  logic        dec_multi_i,
  input  logic        dec_mem_i,
  input  logic        dec_branch_i,
  input  logic        dec_halt_i,
  input  logic        ex_done_i,
  input  logic        mem_ack_i,
  input  logic        irq_i,
  input  logic [15:0] irq_code_i,
  input  logic        nmi_i,
  input  logic        psw_id_i,
  input  logic        psw_np_i,
  output logic        fetch_req_o,
  output logic        dec_en_o,
  output logic        ex_en_o,
  output logic        wb_en_o,
  output logic        mem_req_o,
  output logic [2:0]  pc_inc_o,
  output logic        pc_load_o,
  output logic        exc_take_o,
  output logic        exc_fe_o,
  output logic [15:0] exc_code_o,
  output logic [2:0]  state_o,
  output logic [31:0] instret_o
);

  seq_state_t  state_q,    state_d;
  logic [31:0] instret_q,  instret_d;
  logic        exc_fe_q,   exc_fe_d;
  logic [15:0] exc_code_q, exc_code_d;
  logic [2:0]  pc_inc_q,   pc_inc_d;
  logic        pc_load_q,  pc_load_d;

  logic        nmi_pend_s;
  logic        irq_pend_s;
  logic        wdt_en_s;
  logic        wdt_clear_s;
  logic        wdt_expired_s;

  assign nmi_pend_s = nmi_i & ~psw_np_i;
  assign irq_pend_s = irq_i & ~psw_id_i;

  // A wait cycle is one in which the stage would stay put for lack of a handshake.
  assign wdt_en_s    = ((state_q == ST_EXEC) && dec_multi_i && !ex_done_i) ||
                       ((state_q == ST_MEM) && !mem_ack_i);
  // Any state change restarts the count, which covers entry to EXEC and MEM.
  assign wdt_clear_s = (state_d != state_q);

  seq_watchdog #(
    .WDT_CYCLES (WDT_CYCLES)
  ) u_wdt (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (wdt_clear_s),
    .en_i      (wdt_en_s),
    .expired_o (wdt_expired_s)
  );

  // Next-state, exception latch and WB-strobe preparation.
  always_comb begin
    state_d    = state_q;
    instret_d  = instret_q;
    exc_fe_d   = exc_fe_q;
    exc_code_d = exc_code_q;
    pc_inc_d   = 3'd0;
    pc_load_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_ack_i) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // Completion beats a coincident timeout.
        if (!dec_multi_i || ex_done_i) begin
          state_d = dec_mem_i ? ST_MEM : ST_WB;
        end else if (wdt_expired_s) begin
          state_d    = ST_EXC;
          exc_fe_d   = 1'b1;
          exc_code_d = ECODE_TIMEOUT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_MEM: begin
        if (mem_ack_i) begin
          state_d = ST_WB;
        end else if (wdt_expired_s) begin
          state_d    = ST_EXC;
          exc_fe_d   = 1'b1;
          exc_code_d = ECODE_TIMEOUT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        instret_d = instret_q + 32'd1;
        if (nmi_pend_s || irq_pend_s) begin
          state_d    = ST_EXC;
          exc_fe_d   = nmi_pend_s;
          exc_code_d = nmi_pend_s ? ECODE_NMI : irq_code_i;
        end else if (dec_halt_i) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (nmi_pend_s || irq_pend_s) begin
          state_d    = ST_EXC;
          exc_fe_d   = nmi_pend_s;
          exc_code_d = nmi_pend_s ? ECODE_NMI : irq_code_i;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_EXC: begin
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // PC strobes are registered on WB entry so they are valid for exactly the WB cycle.
    if (state_d == ST_WB) begin
      pc_load_d = dec_branch_i;
      pc_inc_d  = dec_branch_i ? 3'd0 : pc_step(dec_is32_i);
    end else begin
      pc_load_d = 1'b0;
      pc_inc_d  = 3'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      instret_q  <= 32'd0;
      exc_fe_q   <= 1'b0;
      exc_code_q <= 16'h0000;
      pc_inc_q   <= 3'd0;
      pc_load_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instret_q  <= instret_d;
      exc_fe_q   <= exc_fe_d;
      exc_code_q <= exc_code_d;
      pc_inc_q   <= pc_inc_d;
      pc_load_q  <= pc_load_d;
    end
  end

  assign fetch_req_o = (state_q == ST_FETCH);
  assign dec_en_o    = (state_q == ST_DECODE);
  assign ex_en_o     = (state_q == ST_EXEC);
  assign mem_req_o   = (state_q == ST_MEM);
  assign wb_en_o     = (state_q == ST_WB);
  assign exc_take_o  = (state_q == ST_EXC);
  assign pc_inc_o    = pc_inc_q;
  assign pc_load_o   = pc_load_q;
  assign exc_fe_o    = exc_fe_q;
  assign exc_code_o  = exc_code_q;
  assign state_o     = state_q;
  assign instret_o   = instret_q;

endmodule

// File: tb/tb_v850_sequencer.sv
// ---------------------------------------------------------------------------
// tb_v850_sequencer
// Self-checking bench for v850_sequencer. Each scenario drives an instruction
// as the fetch unit / decoder / executer / memory would and compares the
// sequencer outputs cycle by cycle against the behaviour expected from the
// instruction's attributes (stage lengths, PC step, retire count, exception).
// ---------------------------------------------------------------------------
module tb_v850_sequencer;
  import v850_seq_pkg::*;

  localparam int WDT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ack_i, dec_is32_i, dec_multi_i, dec_mem_i, dec_branch_i, dec_halt_i;
  logic        ex_done_i, mem_ack_i, irq_i, nmi_i, psw_id_i, psw_np_i;
  logic [15:0] irq_code_i;
  logic        fetch_req_o, dec_en_o, ex_en_o, wb_en_o, mem_req_o, pc_load_o;
  logic        exc_take_o, exc_fe_o;
  logic [2:0]  pc_inc_o, state_o;
  logic [15:0] exc_code_o;
  logic [31:0] instret_o;

  int checks = 0;
  int errors = 0;
  int exp_instret = 0;

  always #5 clk = ~clk;

  v850_sequencer #(.WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst(rst), .fetch_ack_i(fetch_ack_i), .dec_is32_i(dec_is32_i),
    .dec_multi_i(dec_multi_i), .dec_mem_i(dec_mem_i), .dec_branch_i(dec_branch_i),
    .dec_halt_i(dec_halt_i), .ex_done_i(ex_done_i), .mem_ack_i(mem_ack_i),
    .irq_i(irq_i), .irq_code_i(irq_code_i), .nmi_i(nmi_i), .psw_id_i(psw_id_i),
    .psw_np_i(psw_np_i), .fetch_req_o(fetch_req_o), .dec_en_o(dec_en_o),
    .ex_en_o(ex_en_o), .wb_en_o(wb_en_o), .mem_req_o(mem_req_o), .pc_inc_o(pc_inc_o),
    .pc_load_o(pc_load_o), .exc_take_o(exc_take_o), .exc_fe_o(exc_fe_o),
    .exc_code_o(exc_code_o), .state_o(state_o), .instret_o(instret_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fetch_ack_i = 1'b0; dec_is32_i = 1'b0; dec_multi_i = 1'b0; dec_mem_i = 1'b0;
    dec_branch_i = 1'b0; dec_halt_i = 1'b0; ex_done_i = 1'b0; mem_ack_i = 1'b0;
    irq_i = 1'b0; nmi_i = 1'b0; psw_id_i = 1'b0; psw_np_i = 1'b0; irq_code_i = 16'h0000;
  endtask

  task automatic set_instr(input logic is32, input logic multi, input logic mem,
                           input logic br, input logic halt);
    dec_is32_i = is32; dec_multi_i = multi; dec_mem_i = mem;
    dec_branch_i = br; dec_halt_i = halt;
  endtask

  // From a FETCH cycle: immediate ack, one DECODE cycle, ends in the first EXEC cycle.
  task automatic drive_to_exec();
    fetch_ack_i = 1'b1;
    step();
    fetch_ack_i = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    fetch_ack_i = 1'b1;
    step();
    step();
    checks++;
    if (state_o !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", state_o, ST_IDLE);
    end
    checks++;
    if ({fetch_req_o, dec_en_o, ex_en_o, mem_req_o, wb_en_o, pc_load_o, exc_take_o, exc_fe_o} !== 8'h00 ||
        pc_inc_o !== 3'd0 || exc_code_o !== 16'h0000 || instret_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: strobes=%b pc_inc=%0d code=%h instret=%0d want all zero",
               {fetch_req_o, dec_en_o, ex_en_o, mem_req_o, wb_en_o, pc_load_o, exc_take_o, exc_fe_o},
               pc_inc_o, exc_code_o, instret_o);
    end
    fetch_ack_i = 1'b0;
    rst = 1'b0;
    exp_instret = 0;
    step();
    checks++;
    if (state_o !== ST_FETCH || fetch_req_o !== 1'b1) begin
      errors++; $display("FAIL reset_to_fetch: state=%0d req=%b want state=%0d req=1", state_o, fetch_req_o, ST_FETCH);
    end
  endtask

  task automatic test_alu16();
    logic [2:0] exp_seq [4];
    exp_seq[0] = ST_FETCH; exp_seq[1] = ST_DECODE; exp_seq[2] = ST_EXEC; exp_seq[3] = ST_WB;
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (state_o !== exp_seq[c]) begin
        errors++; $display("FAIL alu16_seq[%0d]: got %0d want %0d", c, state_o, exp_seq[c]);
      end
      fetch_ack_i = (c == 0);
      if (c == 3) begin
        checks++;
        if (wb_en_o !== 1'b1 || pc_inc_o !== 3'd2 || pc_load_o !== 1'b0) begin
          errors++; $display("FAIL alu16_wb: wb_en=%b pc_inc=%0d pc_load=%b want 1 2 0", wb_en_o, pc_inc_o, pc_load_o);
        end
      end
      step();
    end
    fetch_ack_i = 1'b0;
    exp_instret++;
    checks++;
    if (state_o !== ST_FETCH || instret_o !== 32'(exp_instret) || pc_inc_o !== 3'd0) begin
      errors++; $display("FAIL alu16_after: state=%0d instret=%0d pc_inc=%0d want %0d %0d 0",
                         state_o, instret_o, pc_inc_o, ST_FETCH, exp_instret);
    end
  endtask

  task automatic test_random_instrs(input int n);
    for (int k = 0; k < n; k++) begin
      int   fd, ed, md, exp_inc, ex_len;
      logic is32, multi, mem, br;
      fd = $urandom_range(0, 3); ed = $urandom_range(0, 5); md = $urandom_range(0, 4);
      is32 = 1'($urandom); multi = 1'($urandom); mem = 1'($urandom); br = 1'($urandom);
      exp_inc = br ? 0 : (is32 ? 4 : 2);
      ex_len  = multi ? ed + 1 : 1;
      set_instr(is32, multi, mem, br, 1'b0);
      // Masked interrupt noise must never disturb the flow.
      psw_id_i = 1'b1; psw_np_i = 1'b1;
      for (int c = 0; c <= fd; c++) begin
        checks++;
        if (state_o !== ST_FETCH || fetch_req_o !== 1'b1) begin
          errors++; $display("FAIL rnd%0d_fetch: state=%0d req=%b want %0d 1", k, state_o, fetch_req_o, ST_FETCH);
        end
        irq_i = 1'($urandom); nmi_i = 1'($urandom);
        fetch_ack_i = (c == fd);
        step();
      end
      fetch_ack_i = 1'b0;
      checks++;
      if (state_o !== ST_DECODE || dec_en_o !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_decode: state=%0d dec_en=%b want %0d 1", k, state_o, dec_en_o, ST_DECODE);
      end
      step();
      for (int c = 0; c < ex_len; c++) begin
        checks++;
        if (state_o !== ST_EXEC || ex_en_o !== 1'b1) begin
          errors++; $display("FAIL rnd%0d_exec%0d: state=%0d ex_en=%b want %0d 1", k, c, state_o, ex_en_o, ST_EXEC);
        end
        ex_done_i = multi && (c == ed);
        step();
      end
      ex_done_i = 1'b0;
      if (mem) begin
        for (int c = 0; c <= md; c++) begin
          checks++;
          if (state_o !== ST_MEM || mem_req_o !== 1'b1) begin
            errors++; $display("FAIL rnd%0d_mem%0d: state=%0d req=%b want %0d 1", k, c, state_o, mem_req_o, ST_MEM);
          end
          mem_ack_i = (c == md);
          step();
        end
        mem_ack_i = 1'b0;
      end
      checks++;
      if (state_o !== ST_WB || pc_inc_o !== 3'(exp_inc) || pc_load_o !== br || instret_o !== 32'(exp_instret)) begin
        errors++; $display("FAIL rnd%0d_wb: state=%0d pc_inc=%0d load=%b instret=%0d want %0d %0d %b %0d",
                           k, state_o, pc_inc_o, pc_load_o, instret_o, ST_WB, exp_inc, br, exp_instret);
      end
      step();
      exp_instret++;
    end
    irq_i = 1'b0; nmi_i = 1'b0; psw_id_i = 1'b0; psw_np_i = 1'b0;
    checks++;
    if (state_o !== ST_FETCH || instret_o !== 32'(exp_instret)) begin
      errors++; $display("FAIL rnd_end: state=%0d instret=%0d want %0d %0d", state_o, instret_o, ST_FETCH, exp_instret);
    end
  endtask

  task automatic test_load32();
    int n_req = 0;
    set_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_to_exec();
    step();
    for (int c = 0; c < 4; c++) begin
      if (mem_req_o === 1'b1) n_req++;
      mem_ack_i = (c == 3);
      step();
    end
    mem_ack_i = 1'b0;
    checks++;
    if (n_req != 4 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL load32_memreq: high %0d cycles, req_in_wb=%b want 4 0", n_req, mem_req_o);
    end
    checks++;
    if (state_o !== ST_WB || pc_inc_o !== 3'd4 || pc_load_o !== 1'b0) begin
      errors++; $display("FAIL load32_wb: state=%0d pc_inc=%0d load=%b want %0d 4 0", state_o, pc_inc_o, pc_load_o, ST_WB);
    end
    step();
    exp_instret++;
    checks++;
    if (instret_o !== 32'(exp_instret) || state_o !== ST_FETCH) begin
      errors++; $display("FAIL load32_instret: instret=%0d state=%0d want %0d %0d", instret_o, state_o, exp_instret, ST_FETCH);
    end
  endtask

  task automatic test_irq(input logic id, input logic [15:0] code);
    set_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_to_exec();
    irq_i = 1'b1; irq_code_i = code; psw_id_i = id;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (state_o !== ST_EXEC || exc_take_o !== 1'b0) begin
        errors++; $display("FAIL irq_exec%0d: state=%0d take=%b want %0d 0", c, state_o, exc_take_o, ST_EXEC);
      end
      ex_done_i = (c == 2);
      step();
    end
    ex_done_i = 1'b0;
    checks++;
    if (state_o !== ST_WB) begin
      errors++; $display("FAIL irq_wb: state=%0d want %0d", state_o, ST_WB);
    end
    step();
    exp_instret++;
    if (!id) begin
      checks++;
      if (state_o !== ST_EXC || exc_take_o !== 1'b1 || exc_fe_o !== 1'b0 || exc_code_o !== code) begin
        errors++; $display("FAIL irq_exc: state=%0d take=%b fe=%b code=%h want %0d 1 0 %h",
                           state_o, exc_take_o, exc_fe_o, exc_code_o, ST_EXC, code);
      end
      irq_i = 1'b0; irq_code_i = 16'h1234;
      step();
    end
    irq_i = 1'b0; psw_id_i = 1'b0;
    checks++;
    if (state_o !== ST_FETCH || exc_take_o !== 1'b0 || instret_o !== 32'(exp_instret)) begin
      errors++; $display("FAIL irq_fetch(id=%b): state=%0d take=%b instret=%0d want %0d 0 %0d",
                         id, state_o, exc_take_o, instret_o, ST_FETCH, exp_instret);
    end
  endtask

  task automatic test_nmi(input logic np, input logic exp_fe, input logic [15:0] exp_code);
    set_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_to_exec();
    step();
    nmi_i = 1'b1; irq_i = 1'b1; irq_code_i = 16'h0abc; psw_np_i = np; psw_id_i = 1'b0;
    step();
    exp_instret++;
    checks++;
    if (state_o !== ST_EXC || exc_take_o !== 1'b1 || exc_fe_o !== exp_fe || exc_code_o !== exp_code) begin
      errors++; $display("FAIL nmi_exc(np=%b): state=%0d take=%b fe=%b code=%h want %0d 1 %b %h",
                         np, state_o, exc_take_o, exc_fe_o, exc_code_o, ST_EXC, exp_fe, exp_code);
    end
    nmi_i = 1'b0; irq_i = 1'b0; psw_np_i = 1'b0;
    step();
    checks++;
    if (state_o !== ST_FETCH) begin
      errors++; $display("FAIL nmi_fetch: state=%0d want %0d", state_o, ST_FETCH);
    end
  endtask

  task automatic test_watchdog(input logic use_mem, input logic done_last);
    int n = 0;
    logic [2:0] wait_st;
    wait_st = use_mem ? ST_MEM : ST_EXEC;
    set_instr(1'b0, ~use_mem, use_mem, 1'b0, 1'b0);
    drive_to_exec();
    if (use_mem) step();
    for (int c = 0; c < 200 && state_o === wait_st; c++) begin
      n++;
      ex_done_i = done_last && (n == WDT);
      step();
    end
    ex_done_i = 1'b0;
    checks++;
    if (n != WDT) begin
      errors++; $display("FAIL wdt_len(mem=%b done=%b): waited %0d want %0d", use_mem, done_last, n, WDT);
    end
    if (done_last) begin
      checks++;
      if (state_o !== ST_WB || exc_take_o !== 1'b0) begin
        errors++; $display("FAIL wdt_done_wins: state=%0d take=%b want %0d 0", state_o, exc_take_o, ST_WB);
      end
      step();
      exp_instret++;
    end else begin
      checks++;
      if (state_o !== ST_EXC || exc_fe_o !== 1'b1 || exc_code_o !== 16'h0060 || instret_o !== 32'(exp_instret)) begin
        errors++; $display("FAIL wdt_exc(mem=%b): state=%0d fe=%b code=%h instret=%0d want %0d 1 0060 %0d",
                           use_mem, state_o, exc_fe_o, exc_code_o, instret_o, ST_EXC, exp_instret);
      end
      step();
    end
    checks++;
    if (state_o !== ST_FETCH || instret_o !== 32'(exp_instret)) begin
      errors++; $display("FAIL wdt_after: state=%0d instret=%0d want %0d %0d", state_o, instret_o, ST_FETCH, exp_instret);
    end
  endtask

  task automatic test_halt();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_to_exec();
    step();
    step();
    exp_instret++;
    irq_i = 1'b1; psw_id_i = 1'b1; irq_code_i = 16'h0033;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (state_o !== ST_HALT || {fetch_req_o, dec_en_o, ex_en_o, mem_req_o, wb_en_o, exc_take_o} !== 6'b0) begin
        errors++; $display("FAIL halt_hold%0d: state=%0d strobes=%b want %0d 000000", c, state_o,
                           {fetch_req_o, dec_en_o, ex_en_o, mem_req_o, wb_en_o, exc_take_o}, ST_HALT);
      end
      if (c == 9) psw_id_i = 1'b0;
      step();
    end
    checks++;
    if (state_o !== ST_EXC || exc_fe_o !== 1'b0 || exc_code_o !== 16'h0033) begin
      errors++; $display("FAIL halt_exc: state=%0d fe=%b code=%h want %0d 0 0033", state_o, exc_fe_o, exc_code_o, ST_EXC);
    end
    irq_i = 1'b0; dec_halt_i = 1'b0;
    step();
    checks++;
    if (state_o !== ST_FETCH || instret_o !== 32'(exp_instret)) begin
      errors++; $display("FAIL halt_fetch: state=%0d instret=%0d want %0d %0d", state_o, instret_o, ST_FETCH, exp_instret);
    end
  endtask

  task automatic test_rst_in_mem();
    set_instr(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_to_exec();
    step();
    step();
    checks++;
    if (state_o !== ST_MEM) begin
      errors++; $display("FAIL rst_mem_pre: state=%0d want %0d", state_o, ST_MEM);
    end
    rst = 1'b1;
    mem_ack_i = 1'b1;
    step();
    exp_instret = 0;
    checks++;
    if (state_o !== ST_IDLE || mem_req_o !== 1'b0 || instret_o !== 32'd0) begin
      errors++; $display("FAIL rst_mem_idle: state=%0d req=%b instret=%0d want %0d 0 0", state_o, mem_req_o, instret_o, ST_IDLE);
    end
    rst = 1'b0;
    step();
    mem_ack_i = 1'b0;
    step();
    checks++;
    if (state_o !== ST_FETCH || fetch_req_o !== 1'b1 || mem_req_o !== 1'b0) begin
      errors++; $display("FAIL rst_mem_refetch: state=%0d freq=%b mreq=%b want %0d 1 0", state_o, fetch_req_o, mem_req_o, ST_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_alu16();
    test_random_instrs(30);
    test_load32();
    test_irq(1'b0, 16'h0090);
    test_irq(1'b1, 16'h0090);
    test_nmi(1'b0, 1'b1, 16'h0010);
    test_nmi(1'b1, 1'b0, 16'h0abc);
    test_watchdog(1'b0, 1'b0);
    test_watchdog(1'b0, 1'b1);
    test_watchdog(1'b1, 1'b0);
    test_halt();
    test_rst_in_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/v850_sequencer.md
# v850_sequencer

Multi-cycle instruction sequencer for the V850 core. It steps each instruction through fetch, decode, execute, memory and write-back by driving per-stage enables to the decoder and executer. It owns PC advance/load strobes, HALT, interrupt/NMI entry at instruction boundaries, an execute/memory watchdog and the retired-instruction counter.

## Interface
- `WDT_CYCLES`, default 64: cycles EXEC or MEM may wait before a timeout exception.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous and active-high, single clock domain.
- `fetch_ack_i`  in  1  fetch data valid for current request.
- `dec_is32_i`  in  1  decoded instruction is 32-bit; else 16-bit.
- `dec_multi_i`  in  1  multi-cycle execute; wait for `ex_done_i`.
- `dec_mem_i`  in  1  instruction has a load/store phase.
- `dec_branch_i`  in  1  taken branch/jump; PC is loaded, not incremented.
- `dec_halt_i`  in  1  HALT instruction.
- `ex_done_i`  in  1  multi-cycle execute finished.
- `mem_ack_i`  in  1  memory access complete.
- `irq_i`  in  1  maskable interrupt request, level.
- `irq_code_i`  in  16  exception code of the pending interrupt.
- `nmi_i`  in  1  non-maskable interrupt, level.
- `psw_id_i`  in  1  PSW.ID; 1 masks `irq_i`.
- `psw_np_i`  in  1  PSW.NP; 1 masks `nmi_i`.
- `fetch_req_o`  out  1  fetch request.
- `dec_en_o`, `ex_en_o`, `wb_en_o`  out  1 each  stage enables.
- `mem_req_o`  out  1  memory request.
- `pc_inc_o`  out  3  PC increment: 0, 2 or 4.
- `pc_load_o`  out  1  load branch target into PC.
- `exc_take_o`  out  1  exception entry strobe; save PC/PSW into EIPC/EIPSW or FEPC/FEPSW.
- `exc_fe_o`  out  1  with `exc_take_o`: 1 = FE level (NMI, timeout), 0 = EI level.
- `exc_code_o`  out  16  code written to ECR.
- `state_o`  out  3  current state.
- `instret_o`  out  32  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, EXC, HALT.
- IDLE -> FETCH unconditionally.
- FETCH:
  - `fetch_req_o`=1 while in this state.
  - On `fetch_ack_i` -> DECODE. An ack in the first FETCH cycle counts.
- DECODE: `dec_en_o`=1 for one cycle -> EXEC.
- EXEC:
  - `ex_en_o`=1.
  - If `dec_multi_i`=0, leave after one cycle. Otherwise stay until `ex_done_i`.
  - Next state is MEM if `dec_mem_i`, else WB.
- MEM: `mem_req_o`=1 until `mem_ack_i` -> WB.
- WB:
  - `wb_en_o`=1 for one cycle; `instret_o` increments, wrapping at 2^32.
  - If `dec_branch_i`: `pc_load_o`=1, `pc_inc_o`=0. Else `pc_inc_o` = 4 if `dec_is32_i`, otherwise 2.
  - Next state, in priority order: EXC if an NMI or interrupt is pending (see below), then HALT if `dec_halt_i`, else FETCH.
- Pending at WB means `nmi_i` & !`psw_np_i`, or `irq_i` & !`psw_id_i`.
- HALT: all enables 0. A pending NMI or interrupt -> EXC; otherwise stay.
- EXC:
  - One cycle with `exc_take_o`=1, then -> FETCH.
  - `exc_fe_o` and `exc_code_o` are latched when EXC is entered.
- Priority and codes:
  - NMI beats IRQ. NMI: `exc_fe_o`=1, code `ECODE_NMI` (16'h0010).
  - IRQ: `exc_fe_o`=0, code = `irq_code_i` sampled on EXC entry.
- Interrupts are sampled only at WB and in HALT, never mid-instruction.
- Watchdog:
  - Counter clears on entry to EXEC or MEM.
  - Increments each cycle spent waiting in EXEC or MEM.
  - If it reaches `WDT_CYCLES` -> EXC with `exc_fe_o`=1, code `ECODE_TIMEOUT` (16'h0060).
  - No WB occurs, so `instret_o` does not increment.
  - A done/ack arriving in the same cycle as the timeout wins; there is no exception.

## Timing
- Reset values:
  - State IDLE; `instret_o`=0; watchdog=0.
  - All strobes and requests 0; `pc_inc_o`=0; `exc_code_o`=0; `exc_fe_o`=0.
- `rst` asserted in any state: IDLE on the next edge, with all requests dropped that cycle. In-flight fetch/memory acks after reset are ignored.
- All outputs are decoded from registered state/latches only; there is no combinational path from any input to any output.
- Minimum instruction: FETCH(1)+DECODE(1)+EXEC(1)+WB(1) = 4 cycles. MEM adds at least 1 cycle.
- `fetch_req_o` and `mem_req_o` stay high until the ack; the requester must not withdraw a request.
- Interrupt latency from WB: EXC on the next cycle; the first FETCH of the handler follows it.

## Structure
- Package `v850_seq_pkg`:
  - state enum `seq_state_t`, 3-bit.
  - `ECODE_NMI`, `ECODE_TIMEOUT`.
  - PC increment constants `PC_INC16`=2, `PC_INC32`=4.
- One sub-module `seq_watchdog`: counter, clear/enable inputs, `expired` output, parameter `WDT_CYCLES`.

## Test plan
- Reset, 16-bit ALU instruction, immediate acks -> states IDLE, FETCH, DECODE, EXEC, WB, FETCH; `pc_inc_o`=2 in WB; `instret_o`=1.
- 32-bit load, `mem_ack_i` delayed 3 cycles -> `mem_req_o` high 4 cycles; `pc_inc_o`=4; `instret_o` increments once.
- `irq_i`=1, `irq_code_i`=16'h0090, `psw_id_i`=0, asserted during EXEC -> no action until WB, then EXC with `exc_take_o`=1, `exc_fe_o`=0, `exc_code_o`=16'h0090. Repeat with `psw_id_i`=1 -> FETCH, no exception.
- `nmi_i` and `irq_i` together at WB -> `exc_fe_o`=1, `exc_code_o`=16'h0010.
- Multi-cycle op, `ex_done_i` never asserted, `WDT_CYCLES`=64 -> EXC after 64 wait cycles, code 16'h0060, `instret_o` unchanged. Done in the 64th cycle -> WB, no exception.
- HALT, then `irq_i` with `psw_id_i`=0 after 10 cycles -> HALT held 10 cycles, then EXC, then FETCH. `rst` pulsed during MEM -> IDLE, `mem_req_o`=0 next cycle.
